// File: rtl/wb_write_queue.sv
// Four-entry write-back queue between the pipeline WB stage and the register file write port.
// Define WB_FORWARD_EN to enable bypass lookup of pending entries for the two read ports.
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        In_Valid,
  input  logic [4:0]  In_Address,
  input  logic [31:0] In_Data,
  output logic        Full,
  input  logic        Hold,
  output logic        Write_Ctrl,
  output logic [4:0]  Write_Address,
  output logic [31:0] Write_Data,
  input  logic [4:0]  Read_Address1,
  input  logic [4:0]  Read_Address2,
  output logic        Fwd_Hit1,
  output logic        Fwd_Hit2,
  output logic [31:0] Fwd_Data1,
  output logic [31:0] Fwd_Data2,
  output logic [2:0]  Count
);

  localparam int PTR_W = 2;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [2:0]       count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic accept;
  logic pop;

  assign Full   = (count_q == 3'(DEPTH));
  assign accept = In_Valid && !Full && (In_Address != 5'd0);
  assign pop    = (count_q != 3'd0) && !Hold;
  assign Count  = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (accept) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: async reset clears control state only; payload storage is gated by valid bits and needs no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail_q] <= In_Address;
      data_q[tail_q] <= In_Data;
    end
  end

  assign Write_Ctrl    = pop;
  assign Write_Address = pop ? addr_q[head_q] : 5'd0;
  assign Write_Data    = pop ? data_q[head_q] : 32'd0;

`ifdef WB_FORWARD_EN
  // Scan oldest to newest so the last match (closest to tail) wins.
  always_comb begin : fwd_lookup
    logic [PTR_W-1:0] idx;
    Fwd_Hit1  = 1'b0;
    Fwd_Hit2  = 1'b0;
    Fwd_Data1 = 32'd0;
    Fwd_Data2 = 32'd0;
    idx       = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (Read_Address1 != 5'd0) && (addr_q[idx] == Read_Address1)) begin
        Fwd_Hit1  = 1'b1;
        Fwd_Data1 = data_q[idx];
      end
      if (valid_q[idx] && (Read_Address2 != 5'd0) && (addr_q[idx] == Read_Address2)) begin
        Fwd_Hit2  = 1'b1;
        Fwd_Data2 = data_q[idx];
      end
    end
  end
`else
  logic unused_read_addr;
  assign unused_read_addr = ^{Read_Address1, Read_Address2};
  assign Fwd_Hit1  = 1'b0;
  assign Fwd_Hit2  = 1'b0;
  assign Fwd_Data1 = 32'd0;
  assign Fwd_Data2 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue; forwarding expectations follow WB_FORWARD_EN.
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        In_Valid;
  logic [4:0]  In_Address;
  logic [31:0] In_Data;
  logic        Full;
  logic        Hold;
  logic        Write_Ctrl;
  logic [4:0]  Write_Address;
  logic [31:0] Write_Data;
  logic [4:0]  Read_Address1;
  logic [4:0]  Read_Address2;
  logic        Fwd_Hit1;
  logic        Fwd_Hit2;
  logic [31:0] Fwd_Data1;
  logic [31:0] Fwd_Data2;
  logic [2:0]  Count;

  int checks = 0;
  int passed = 0;

  wb_write_queue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .In_Valid      (In_Valid),
    .In_Address    (In_Address),
    .In_Data       (In_Data),
    .Full          (Full),
    .Hold          (Hold),
    .Write_Ctrl    (Write_Ctrl),
    .Write_Address (Write_Address),
    .Write_Data    (Write_Data),
    .Read_Address1 (Read_Address1),
    .Read_Address2 (Read_Address2),
    .Fwd_Hit1      (Fwd_Hit1),
    .Fwd_Hit2      (Fwd_Hit2),
    .Fwd_Data1     (Fwd_Data1),
    .Fwd_Data2     (Fwd_Data2),
    .Count         (Count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic ctrl, input logic [4:0] a,
                             input logic [31:0] d, input logic [2:0] cnt);
    check({tag, ".ctrl"},  32'(Write_Ctrl),    32'(ctrl));
    check({tag, ".addr"},  32'(Write_Address), 32'(a));
    check({tag, ".data"},  Write_Data,         d);
    check({tag, ".count"}, 32'(Count),         32'(cnt));
  endtask

  task automatic check_idle(input string tag);
    check_write(tag, 1'b0, 5'd0, 32'd0, 3'd0);
    check({tag, ".full"},  32'(Full),     32'd0);
    check({tag, ".hit1"},  32'(Fwd_Hit1), 32'd0);
    check({tag, ".hit2"},  32'(Fwd_Hit2), 32'd0);
    check({tag, ".fdat1"}, Fwd_Data1,     32'd0);
    check({tag, ".fdat2"}, Fwd_Data2,     32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    In_Valid      = 1'b0;
    In_Address    = 5'd0;
    In_Data       = 32'd0;
    Hold          = 1'b0;
    Read_Address1 = 5'd0;
    Read_Address2 = 5'd0;

    // Reset state
    #12;
    check_idle("reset");
    rst_n = 1'b1;

    // Single request, one-cycle latency then drain
    In_Valid = 1'b1; In_Address = 5'd20; In_Data = 32'd1023;
    step();
    In_Valid = 1'b0;
    check_write("single", 1'b1, 5'd20, 32'd1023, 3'd1);
    step();
    check_write("single_done", 1'b0, 5'd0, 32'd0, 3'd0);

    // Address 0 request is consumed without enqueue
    In_Valid = 1'b1; In_Address = 5'd0; In_Data = 32'd99;
    step();
    In_Valid = 1'b0;
    check_write("zero_addr", 1'b0, 5'd0, 32'd0, 3'd0);
    step();
    check_write("zero_addr2", 1'b0, 5'd0, 32'd0, 3'd0);

    // Fill under Hold; fifth request refused and held
    Hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      In_Valid = 1'b1; In_Address = 5'(i); In_Data = 32'(11 * i);
      step();
      if (i == 3) check("fill3.full", 32'(Full), 32'd0);
    end
    check("fill.full",  32'(Full),       32'd1);
    check("fill.count", 32'(Count),      32'd4);
    check("fill.wctl",  32'(Write_Ctrl), 32'd0);

    // Release Hold with request 5 still pending; Full does not see same-cycle drain
    Hold = 1'b0;
    #1;
    check_write("drain1", 1'b1, 5'd1, 32'd11, 3'd4);
    check("drain1.full", 32'(Full), 32'd1);
    step();
    check_write("drain2", 1'b1, 5'd2, 32'd22, 3'd3);
    check("drain2.full", 32'(Full), 32'd0);
    step();
    In_Valid = 1'b0;
    check_write("drain3", 1'b1, 5'd3, 32'd33, 3'd3);
    step();
    check_write("drain4", 1'b1, 5'd4, 32'd44, 3'd2);
    step();
    check_write("drain5", 1'b1, 5'd5, 32'd55, 3'd1);
    step();
    check_write("drained", 1'b0, 5'd0, 32'd0, 3'd0);

    // Forwarding: two entries for reg 18, newest wins
    Hold = 1'b1; Read_Address1 = 5'd18; Read_Address2 = 5'd0;
    In_Valid = 1'b1; In_Address = 5'd18; In_Data = 32'd1553;
    step();
`ifdef WB_FORWARD_EN
    check("fwd_a.hit1",  32'(Fwd_Hit1), 32'd1);
    check("fwd_a.data1", Fwd_Data1,      32'd1553);
`else
    check("fwd_a.hit1",  32'(Fwd_Hit1), 32'd0);
    check("fwd_a.data1", Fwd_Data1,      32'd0);
`endif
    In_Data = 32'd7;
    step();
    In_Address = 5'd3; In_Data = 32'd33;
`ifdef WB_FORWARD_EN
    check("fwd_b.hit1",  32'(Fwd_Hit1), 32'd1);
    check("fwd_b.data1", Fwd_Data1,      32'd7);
`else
    check("fwd_b.hit1",  32'(Fwd_Hit1), 32'd0);
    check("fwd_b.data1", Fwd_Data1,      32'd0);
`endif
    check("fwd_b.hit2",  32'(Fwd_Hit2), 32'd0);
    check("fwd_b.data2", Fwd_Data2,      32'd0);
    step();
    In_Valid = 1'b0;
    check("pend3.count", 32'(Count), 32'd3);

    // Mid-cycle reset with three pending entries
    #2;
    Hold  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    step();
    check_idle("midrst_hold");
    #2;
    rst_n = 1'b1;
    step();
    check_idle("post_rst");

    // First acceptance at the first edge after release
    In_Valid = 1'b1; In_Address = 5'd7; In_Data = 32'd77;
    step();
    In_Valid = 1'b0;
    check_write("first_acc", 1'b1, 5'd7, 32'd77, 3'd1);
    step();
    check_write("first_acc_done", 1'b0, 5'd0, 32'd0, 3'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of pending write-back entries (fixed at 4 in this revision).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 In_Valid  input  1  write-back request from the pipeline WB stage.
REQ-005 In_Address  input  5  destination register of the request.
REQ-006 In_Data  input  32  result value of the request.
REQ-007 Full  output  1  queue holds DEPTH entries; request refused.
REQ-008 Hold  input  1  register file write port unavailable this cycle.
REQ-009 Write_Ctrl  output  1  write strobe to register file write port.
REQ-010 Write_Address  output  5  register file write address.
REQ-011 Write_Data  output  32  register file write data.
REQ-012 Read_Address1, Read_Address2  input  5 each  addresses currently being read from the register file.
REQ-013 Fwd_Hit1, Fwd_Hit2  output  1 each  pending entry matches the corresponding read address.
REQ-014 Fwd_Data1, Fwd_Data2  output  32 each  newest pending value for the corresponding read address.
REQ-015 Count  output  3  number of valid entries, 0..4.

Function
REQ-016 Storage SHALL be a 4-entry circular FIFO with 2-bit head/tail pointers that wrap 3->0.
REQ-017 A request SHALL be accepted at a rising edge iff In_Valid=1, Full=0 and In_Address!=0.
REQ-018 A request with In_Address=0 SHALL be consumed with no enqueue and no effect on Count.
REQ-019 A request with Full=1 SHALL be refused; the requester holds it (stall) until Full=0.
REQ-020 Full SHALL equal (Count==4), combinational from state, independent of same-cycle drain.
REQ-021 Write_Ctrl SHALL equal (Count!=0) and Hold=0; Write_Address/Write_Data SHALL be the head entry combinationally.
REQ-022 When Write_Ctrl=1, the head entry SHALL be popped at that rising edge (one write per cycle).
REQ-023 Latency: an entry accepted at edge N SHALL appear on the write port no earlier than the cycle after edge N; with an empty queue and Hold=0, exactly that cycle.
REQ-024 Simultaneous accept and pop SHALL leave Count unchanged; accept only -> Count+1; pop only -> Count-1.
REQ-025 Entries SHALL drain in strict acceptance order; same-address entries are all written, in order.
REQ-026 Hold=1 SHALL freeze the head and pointers for drain purposes; acceptance continues until Full.
REQ-027 When Write_Ctrl=0, Write_Address and Write_Data SHALL be 0.

Reset
REQ-028 rst_n=0 SHALL immediately clear Count, head, tail and all entry valid bits, regardless of clk.
REQ-029 During and after reset: Full=0, Write_Ctrl=0, Write_Address=0, Write_Data=0, Fwd_Hit1/2=0, Fwd_Data1/2=0, Count=0.
REQ-030 Reset mid-operation SHALL discard all pending entries; no partial write is issued.
REQ-031 The first acceptance SHALL occur at the first rising edge with rst_n=1.

Configuration
REQ-032 Macro WB_FORWARD_EN controls bypass lookup.
REQ-033 With WB_FORWARD_EN defined: Fwd_HitK=1 iff a valid entry has address==Read_AddressK and Read_AddressK!=0; Fwd_DataK = data of the newest (closest to tail) such entry; combinational; the incoming In_* request is not searched.
REQ-034 Without WB_FORWARD_EN: Fwd_Hit1/2 and Fwd_Data1/2 SHALL be constant 0 and no comparators are synthesised.

Verification
REQ-035 Reset then In_Valid=1, In_Address=20, In_Data=1023 for one cycle, Hold=0 -> next cycle Write_Ctrl=1, Write_Address=20, Write_Data=1023; following cycle Count=0, Write_Ctrl=0.
REQ-036 Hold=1, five requests to regs 1..5 data 11..55 on consecutive cycles -> Full=1 after fourth; fifth refused; release Hold -> writes 1/11, 2/22, 3/33, 4/44 in order on four consecutive cycles.
REQ-037 Full queue, Hold=0, In_Valid=1 -> request refused that edge, Count goes 4->3, accepted on the next edge, Count stays 3.
REQ-038 WB_FORWARD_EN, Hold=1, queue reg 18 data 1553 then reg 18 data 7, Read_Address1=18, Read_Address2=0 -> Fwd_Hit1=1, Fwd_Data1=7, Fwd_Hit2=0; without macro -> both hits 0.
REQ-039 In_Address=0, In_Data=99 accepted -> Count stays 0, no Write_Ctrl pulse.
REQ-040 Three entries pending, rst_n pulsed low mid-cycle -> outputs 0 immediately, no write of pending entries after release.
